xbar_route_sequencer: RTL and testbench
=======================================

XBAR_ROUTE_SEQUENCER -- requirements
Module: xbar_route_sequencer

Interface
REQ-001 SHALL have parameter IP_COUNT, default 3: crossbar input count.
REQ-002 SHALL have parameter OP_COUNT, default 3: crossbar output count.
REQ-003 SHALL have parameter REST_ADDR, default IP_COUNT*OP_COUNT: no-toggle address.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(IP_COUNT*OP_COUNT+1): crossbar select width.
REQ-005 SHALL have parameter IN_W, default $clog2(IP_COUNT) (min 1), and OUT_W, default $clog2(OP_COUNT) (min 1).
REQ-006 Clk  input  1  clock; all state updates on rising edge.
REQ-007 Rst  input  1  reset, asynchronous, active-high.
REQ-008 req_valid  input  1  route request present.
REQ-009 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-010 req_op  input  2  00 connect, 01 disconnect, 10 clear-all, 11 illegal.
REQ-011 req_in  input  IN_W  source input index.
REQ-012 req_out  input  OUT_W  destination output index.
REQ-013 addr_sel  output  ADDR_WIDTH  crossbar toggle address (row*OP_COUNT+column), REST_ADDR when idle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at request completion.
REQ-016 err  output  1  valid with done; 1 = request rejected, no toggles issued.
REQ-017 route_map  output  IP_COUNT*OP_COUNT  shadow connection map, bit i*OP_COUNT+j = input i drives output j.

Function
REQ-018 SHALL use states IDLE, CHECK, UNSET, GAP, SET, CLR_SCAN, CLR_GAP, DONE.
REQ-019 Accept in IDLE; latch op/in/out; next state CHECK.
REQ-020 CHECK: op 11, req_in>=IP_COUNT or req_out>=OP_COUNT (connect/disconnect only) -> DONE with err=1.
REQ-021 Connect, map[in][out] already 1 -> DONE, no toggle.
REQ-022 Connect, other input k owns out -> UNSET (addr_sel=k*OP_COUNT+out), GAP (REST_ADDR), SET (addr_sel=in*OP_COUNT+out), DONE.
REQ-023 Connect, output column free -> SET then DONE.
REQ-024 Disconnect, map[in][out]=1 -> SET (same address, toggles off) then DONE; map bit 0 -> DONE, no toggle.
REQ-025 Clear-all: CLR_SCAN visits map bits in ascending index; each set bit emits its address for one cycle followed by one CLR_GAP cycle of REST_ADDR; no set bits remaining -> DONE.
REQ-026 Any non-REST addr_sel value SHALL be driven for exactly one cycle, always followed by at least one REST_ADDR cycle.
REQ-027 Shadow map bit SHALL update in the same cycle its toggle address is driven.
REQ-028 At most one set bit per map column at all times.
REQ-029 DONE: done=1 for one cycle, addr_sel=REST_ADDR, next state IDLE; err cleared on the next accept.
REQ-030 Latency: fresh connect accepted cycle 0 -> addr cycle 2 -> done cycle 3; replacing connect done cycle 5.
REQ-031 req_valid while busy SHALL be ignored (not queued); request fields SHALL be sampled only at accept.

Reset
REQ-032 On Rst: state IDLE, addr_sel=REST_ADDR, route_map=0, busy=0, done=0, err=0, req_ready=1 the cycle after release.
REQ-033 Rst mid-sequence SHALL abort with no further toggles; the crossbar is reset by the same Rst, so map=0 stays consistent.

Structure
REQ-034 Shared package xbar_pkg SHALL hold the op encodings, the state enum, and a rest-address function of IP_COUNT and OP_COUNT.
REQ-035 No sub-module; the map, FSM and scan counter are in one module, instantiated beside the crossbar in the datapath top.

Verification (3x3, REST_ADDR=9)
REQ-036 Connect in1->out2 from reset -> addr_sel=5 for exactly one cycle, done at cycle 3, route_map bit 5 set, err=0.
REQ-037 Then connect in0->out2 -> addr_sel sequence 5, 9, 2, done; route_map bit 2 only in column 2.
REQ-038 Disconnect in2->out0 with map bit 6 clear -> no non-9 addr_sel, done with err=0.
REQ-039 Map {in0->out0, in2->out1}, clear-all -> addr_sel 0, 9, 7, 9, done; route_map=0.
REQ-040 Connect req_in=3 or req_op=11 -> done with err=1, addr_sel stays 9, map unchanged.
REQ-041 Assert Rst during GAP of a replacing connect -> addr_sel=9, route_map=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar route sequencer: request opcodes,
// sequencer states and the idle (no-toggle) address helper.
package xbar_pkg;

    typedef enum logic [1:0] {
        OP_CONNECT    = 2'b00,
        OP_DISCONNECT = 2'b01,
        OP_CLEAR      = 2'b10,
        OP_ILLEGAL    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        UNSET,
        GAP,
        SET,
        CLR_SCAN,
        CLR_GAP,
        DONE
    } state_e;

    function automatic int rest_addr(input int ip_count, input int op_count);
        return ip_count * op_count;
    endfunction

endpackage

// File: rtl/xbar_route_sequencer.sv
// Sequences one-cycle toggle addresses into a toggle-cell crossbar and keeps a
// shadow map of which input drives each output.
module xbar_route_sequencer
    import xbar_pkg::*;
#(
    parameter int IP_COUNT   = 3,
    parameter int OP_COUNT   = 3,
    parameter int REST_ADDR  = rest_addr(IP_COUNT, OP_COUNT),
    parameter int ADDR_WIDTH = $clog2(IP_COUNT * OP_COUNT + 1),
    parameter int IN_W       = (IP_COUNT > 1) ? $clog2(IP_COUNT) : 1,
    parameter int OUT_W      = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [IN_W-1:0]                req_in,
    input  logic [OUT_W-1:0]               req_out,
    output logic [ADDR_WIDTH-1:0]          addr_sel,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [IP_COUNT*OP_COUNT-1:0]   route_map
);

    localparam int MAP_W = IP_COUNT * OP_COUNT;
    localparam logic [ADDR_WIDTH-1:0] REST = ADDR_WIDTH'(REST_ADDR);

    state_e                  state_q, state_d;
    logic [1:0]              op_q;
    logic [IN_W-1:0]         in_q;
    logic [OUT_W-1:0]        out_q;
    logic                    err_q, err_d;
    logic [MAP_W-1:0]        map_q, map_d;
    logic [ADDR_WIDTH-1:0]   scan_q, scan_d;
    logic [ADDR_WIDTH-1:0]   addr_d;

    logic                    accept;
    logic                    range_bad;
    logic [ADDR_WIDTH-1:0]   cell_addr;
    logic [MAP_W-1:0]        cell_mask;
    logic                    cell_hit;
    logic                    owner_found;
    logic [ADDR_WIDTH-1:0]   owner_addr;
    logic [MAP_W-1:0]        owner_mask;
    logic                    scan_found;
    logic [ADDR_WIDTH-1:0]   scan_addr;
    logic [MAP_W-1:0]        scan_mask;

    assign accept    = (state_q == IDLE) && req_valid;
    assign range_bad = (32'(in_q) >= 32'(IP_COUNT)) || (32'(out_q) >= 32'(OP_COUNT));
    assign cell_addr = ADDR_WIDTH'(32'(in_q) * 32'(OP_COUNT) + 32'(out_q));
    assign cell_mask = MAP_W'(1) << (32'(in_q) * 32'(OP_COUNT) + 32'(out_q));
    assign cell_hit  = (map_q & cell_mask) != '0;

    // Another input currently holding the requested output column.
    always_comb begin
        owner_found = 1'b0;
        owner_addr  = REST;
        owner_mask  = '0;
        for (int unsigned k = 0; k < IP_COUNT; k++) begin
            if (!owner_found && (k != 32'(in_q)) &&
                ((map_q & (MAP_W'(1) << (k * 32'(OP_COUNT) + 32'(out_q)))) != '0)) begin
                owner_found = 1'b1;
                owner_addr  = ADDR_WIDTH'(k * 32'(OP_COUNT) + 32'(out_q));
                owner_mask  = MAP_W'(1) << (k * 32'(OP_COUNT) + 32'(out_q));
            end
        end
    end

    // Lowest set map bit at or above the scan pointer.
    always_comb begin
        scan_found = 1'b0;
        scan_addr  = REST;
        scan_mask  = '0;
        for (int unsigned i = 0; i < MAP_W; i++) begin
            if (!scan_found && (i >= 32'(scan_q)) && (((map_q >> i) & MAP_W'(1)) != '0)) begin
                scan_found = 1'b1;
                scan_addr  = ADDR_WIDTH'(i);
                scan_mask  = MAP_W'(1) << i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        err_d   = err_q;
        scan_d  = scan_q;
        addr_d  = REST;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (op_q == OP_ILLEGAL || (op_q != OP_CLEAR && range_bad)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (op_q == OP_CONNECT) begin
                    if (cell_hit)         state_d = DONE;
                    else if (owner_found) state_d = UNSET;
                    else                  state_d = SET;
                end else if (op_q == OP_DISCONNECT) begin
                    state_d = cell_hit ? SET : DONE;
                end else begin
                    scan_d  = '0;
                    state_d = CLR_SCAN;
                end
            end
            UNSET: begin
                addr_d  = owner_addr;
                map_d   = map_q & ~owner_mask;
                state_d = GAP;
            end
            GAP: state_d = SET;
            // Toggle cell: connects a free cell, disconnects an owned one.
            SET: begin
                addr_d  = cell_addr;
                map_d   = map_q ^ cell_mask;
                state_d = DONE;
            end
            CLR_SCAN: begin
                if (scan_found) begin
                    addr_d  = scan_addr;
                    map_d   = map_q & ~scan_mask;
                    scan_d  = scan_addr + ADDR_WIDTH'(1);
                    state_d = CLR_GAP;
                end else begin
                    state_d = DONE;
                end
            end
            CLR_GAP: state_d = CLR_SCAN;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            map_q   <= '0;
            err_q   <= 1'b0;
            scan_q  <= '0;
            op_q    <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            err_q   <= err_d;
            scan_q  <= scan_d;
            if (accept) begin
                op_q  <= req_op;
                in_q  <= req_in;
                out_q <= req_out;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign addr_sel  = addr_d;
    assign route_map = map_q;

endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Directed bench for the 3x3 route sequencer with hand-computed addresses,
// latencies and shadow-map values.
module tb_xbar_route_sequencer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [1:0] req_in = 2'b00;
    logic [1:0] req_out = 2'b00;
    logic [3:0] addr_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] route_map;

    int tests_run = 0;
    int tests_failed = 0;
    int gap_viol = 0;
    int col_viol = 0;
    logic prev_nonrest = 1'b0;
    int addr_q[$];

    xbar_route_sequencer #(.IP_COUNT(3), .OP_COUNT(3)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_in(req_in), .req_out(req_out), .addr_sel(addr_sel),
        .busy(busy), .done(done), .err(err), .route_map(route_map)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Non-rest addresses must be isolated; each map column has at most one owner.
    always @(negedge Clk) begin
        if (Rst) begin
            prev_nonrest = 1'b0;
        end else begin
            if (prev_nonrest && addr_sel != 4'd9) gap_viol++;
            prev_nonrest = (addr_sel != 4'd9);
            for (int j = 0; j < 3; j++) begin
                if (int'(route_map[j]) + int'(route_map[3 + j]) + int'(route_map[6 + j]) > 1)
                    col_viol++;
            end
        end
    end

    task automatic run_req(input string tag, input logic [1:0] op, input logic [1:0] in_i,
                           input logic [1:0] out_i, input bit noisy, input int exp_cyc,
                           input int exp_n, input int e0, input int e1,
                           input int exp_err, input int exp_map);
        int cyc;
        bit seen;
        addr_q.delete();
        @(negedge Clk);
        req_valid = 1'b1;
        req_op = op;
        req_in = in_i;
        req_out = out_i;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'b10;
        req_in = 2'b01;
        req_out = 2'b01;
        seen = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge Clk);
            if (noisy) req_valid = (c == 1);
            if (addr_sel != 4'd9) addr_q.push_back(int'(addr_sel));
            if (done) begin
                seen = 1'b1;
                cyc = c;
                check({tag, "_err"}, int'(err), exp_err);
                check({tag, "_map"}, int'(route_map), exp_map);
            end
        end
        req_valid = 1'b0;
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_naddr"}, addr_q.size(), exp_n);
        if (exp_n >= 1 && addr_q.size() >= 1) check({tag, "_addr0"}, addr_q[0], e0);
        if (exp_n >= 2 && addr_q.size() >= 2) check({tag, "_addr1"}, addr_q[1], e1);
        @(negedge Clk);
        check({tag, "_idle"}, int'(req_ready), 1);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_addr", int'(addr_sel), 9);
        check("rst_map", int'(route_map), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(req_ready), 1);

        run_req("conn_1_2", 2'b00, 2'd1, 2'd2, 1'b0, 3, 1, 5, 0, 0, 32);
        run_req("repl_0_2", 2'b00, 2'd0, 2'd2, 1'b1, 5, 2, 5, 2, 0, 4);
        run_req("conn_dup", 2'b00, 2'd0, 2'd2, 1'b0, 2, 0, 0, 0, 0, 4);
        run_req("disc_clr", 2'b01, 2'd2, 2'd0, 1'b0, 2, 0, 0, 0, 0, 4);
        run_req("disc_0_2", 2'b01, 2'd0, 2'd2, 1'b0, 3, 1, 2, 0, 0, 0);
        run_req("conn_0_0", 2'b00, 2'd0, 2'd0, 1'b0, 3, 1, 0, 0, 0, 1);
        run_req("conn_2_1", 2'b00, 2'd2, 2'd1, 1'b0, 3, 1, 7, 0, 0, 129);
        run_req("clear", 2'b10, 2'd0, 2'd0, 1'b0, 7, 2, 0, 7, 0, 0);
        run_req("conn_1_1", 2'b00, 2'd1, 2'd1, 1'b0, 3, 1, 4, 0, 0, 16);
        run_req("bad_in", 2'b00, 2'd3, 2'd0, 1'b0, 2, 0, 0, 0, 1, 16);
        run_req("bad_op", 2'b11, 2'd0, 2'd0, 1'b0, 2, 0, 0, 0, 1, 16);
        run_req("bad_out", 2'b01, 2'd1, 2'd3, 1'b0, 2, 0, 0, 0, 1, 16);
        run_req("conn_2_2", 2'b00, 2'd2, 2'd2, 1'b0, 3, 1, 8, 0, 0, 272);

        // Replace in1->out1 with in0->out1, then reset during the GAP cycle.
        @(negedge Clk);
        req_valid = 1'b1;
        req_op = 2'b00;
        req_in = 2'd0;
        req_out = 2'd1;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_unset_addr", int'(addr_sel), 4);
        @(negedge Clk);
        check("abort_gap_addr", int'(addr_sel), 9);
        Rst = 1'b1;
        #1;
        check("abort_addr", int'(addr_sel), 9);
        check("abort_map", int'(route_map), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check("abort_quiet_done", int'(done), 0);
            check("abort_quiet_addr", int'(addr_sel), 9);
        end
        check("abort_ready", int'(req_ready), 1);

        check("gap_rule_violations", gap_viol, 0);
        check("column_rule_violations", col_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
